ines_loader: RTL and testbench

INES_LOADER -- requirements
Module: ines_loader

---
 rtl/ines_loader.sv | 139 +++++++++++++
 tb/tb_ines_loader.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ines_loader.sv
// iNES image loader: parses the 16-byte header, skips an optional trainer, and
// streams PRG then CHR payload bytes into memory as one registered write per byte.
module ines_loader #(
   parameter logic [21:0] PRG_BASE = 22'h000000,
   parameter logic [21:0] CHR_BASE = 22'h200000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  indata,
   input  logic        indata_clk,
   output logic [21:0] mem_addr,
   output logic [7:0]  mem_data,
   output logic        mem_write,
   output logic [7:0]  mapper,
   output logic        mirroring,
   output logic [7:0]  prg_units,
   output logic [7:0]  chr_units,
   output logic        chr_ram,
   output logic        done,
   output logic        error
);

   typedef enum logic [2:0] {HEADER, TRAINER, PRG, CHR, DONE, ERROR} state_t;

   state_t      state;
   logic [3:0]  hdr_cnt;
   logic [21:0] byte_cnt;
   logic        has_trainer;
   logic [7:0]  magic_byte;
   logic [21:0] prg_last;
   logic [21:0] chr_last;

   // prg_units is limited to 128 before PRG is entered, so 128*16K fits in 22 bits.
   assign prg_last = {prg_units, 14'd0} - 22'd1;
   assign chr_last = {1'b0, chr_units, 13'd0} - 22'd1;

   always_comb begin
      magic_byte = 8'h4E;
      case (hdr_cnt[1:0])
         2'd0:    magic_byte = 8'h4E;
         2'd1:    magic_byte = 8'h45;
         2'd2:    magic_byte = 8'h53;
         default: magic_byte = 8'h1A;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= HEADER;
         hdr_cnt     <= 4'd0;
         byte_cnt    <= 22'd0;
         has_trainer <= 1'b0;
         mem_addr    <= 22'd0;
         mem_data    <= 8'd0;
         mem_write   <= 1'b0;
         mapper      <= 8'd0;
         mirroring   <= 1'b0;
         prg_units   <= 8'd0;
         chr_units   <= 8'd0;
         chr_ram     <= 1'b0;
         done        <= 1'b0;
         error       <= 1'b0;
      end else begin
         mem_write <= 1'b0;
         if (indata_clk) begin
            case (state)
               HEADER: begin
                  hdr_cnt <= hdr_cnt + 4'd1;
                  case (hdr_cnt)
                     4'd4: prg_units <= indata;
                     4'd5: begin
                        chr_units <= indata;
                        chr_ram   <= (indata == 8'd0);
                     end
                     4'd6: begin
                        mapper[3:0] <= indata[7:4];
                        mirroring   <= indata[0];
                        has_trainer <= indata[2];
                     end
                     4'd7: mapper[7:4] <= indata[7:4];
                     default: ;
                  endcase
                  if (hdr_cnt < 4'd4 && indata != magic_byte) begin
                     state <= ERROR;
                     error <= 1'b1;
                  end else if (hdr_cnt == 4'd15) begin
                     if (prg_units == 8'd0 || prg_units > 8'd128) begin
                        state <= ERROR;
                        error <= 1'b1;
                     end else if (has_trainer) begin
                        state <= TRAINER;
                     end else begin
                        state <= PRG;
                     end
                  end
               end
               TRAINER: begin
                  if (byte_cnt == 22'd511) begin
                     byte_cnt <= 22'd0;
                     state    <= PRG;
                  end else begin
                     byte_cnt <= byte_cnt + 22'd1;
                  end
               end
               PRG: begin
                  mem_write <= 1'b1;
                  mem_addr  <= PRG_BASE + byte_cnt;
                  mem_data  <= indata;
                  if (byte_cnt == prg_last) begin
                     byte_cnt <= 22'd0;
                     if (chr_units == 8'd0) begin
                        state <= DONE;
                        done  <= 1'b1;
                     end else begin
                        state <= CHR;
                     end
                  end else begin
                     byte_cnt <= byte_cnt + 22'd1;
                  end
               end
               CHR: begin
                  mem_write <= 1'b1;
                  mem_addr  <= CHR_BASE + byte_cnt;
                  mem_data  <= indata;
                  if (byte_cnt == chr_last) begin
                     byte_cnt <= 22'd0;
                     state    <= DONE;
                     done     <= 1'b1;
                  end else begin
                     byte_cnt <= byte_cnt + 22'd1;
                  end
               end
               default: ;  // DONE and ERROR swallow bytes until reset
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ines_loader.sv
// Random iNES images checked against an expected write list derived from the file format.
module tb_ines_loader;
   localparam logic [21:0] PRG_BASE = 22'h000000;
   localparam logic [21:0] CHR_BASE = 22'h200000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  indata = 8'd0;
   logic        indata_clk = 1'b0;
   logic [21:0] mem_addr;
   logic [7:0]  mem_data;
   logic        mem_write;
   logic [7:0]  mapper, prg_units, chr_units;
   logic        mirroring, chr_ram, done, error;

   int tests = 0, fails = 0;
   logic [7:0]  img[$];
   logic [21:0] exp_addr[$];
   logic [7:0]  exp_data[$];
   int          wr_cnt = 0, wr_bad = 0, early_done = 0, both_hi = 0;
   logic        done_at_last = 1'b0;
   logic [7:0]  first_data = 8'd0;

   ines_loader #(.PRG_BASE(PRG_BASE), .CHR_BASE(CHR_BASE)) dut (
      .clk(clk), .reset(reset), .indata(indata), .indata_clk(indata_clk),
      .mem_addr(mem_addr), .mem_data(mem_data), .mem_write(mem_write),
      .mapper(mapper), .mirroring(mirroring), .prg_units(prg_units),
      .chr_units(chr_units), .chr_ram(chr_ram), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Header plus random payload; malformed images get only a short random tail.
   task automatic build_image(input logic [7:0] prg, input logic [7:0] chr,
                              input logic [7:0] f6, input logic [7:0] f7);
      int n;
      img.delete();
      img.push_back(8'h4E); img.push_back(8'h45); img.push_back(8'h53); img.push_back(8'h1A);
      img.push_back(prg); img.push_back(chr); img.push_back(f6); img.push_back(f7);
      for (int i = 0; i < 8; i++) img.push_back(8'h00);
      if (prg == 8'd0 || prg > 8'd128) n = 40;
      else n = (f6[2] ? 512 : 0) + int'(prg) * 16384 + int'(chr) * 8192;
      for (int i = 0; i < n; i++) img.push_back(8'($urandom));
   endtask

   // Expected memory writes straight from the file layout.
   task automatic model();
      int tr, np, nc;
      logic [7:0] f6;
      exp_addr.delete();
      exp_data.delete();
      if (img[0] != 8'h4E || img[1] != 8'h45 || img[2] != 8'h53 || img[3] != 8'h1A) return;
      if (img[4] == 8'd0 || img[4] > 8'd128) return;
      f6 = img[6];
      tr = f6[2] ? 512 : 0;
      np = int'(img[4]) * 16384;
      nc = int'(img[5]) * 8192;
      for (int i = 0; i < np; i++) begin
         exp_addr.push_back(PRG_BASE + 22'(i));
         exp_data.push_back(img[16 + tr + i]);
      end
      for (int i = 0; i < nc; i++) begin
         exp_addr.push_back(CHR_BASE + 22'(i));
         exp_data.push_back(img[16 + tr + np + i]);
      end
   endtask

   task automatic clear_mon();
      wr_cnt = 0; wr_bad = 0; early_done = 0; done_at_last = 1'b0;
   endtask

   // mode 0: continuous, 1: every third cycle, 2: random gaps
   task automatic send(input int start, input int n, input int mode);
      int g;
      for (int i = start; i < start + n; i++) begin
         g = 0;
         if (mode == 1) g = 2;
         else if (mode == 2 && $urandom_range(0, 9) == 0) g = int'($urandom_range(1, 3));
         repeat (g) begin @(negedge clk); indata_clk = 1'b0; end
         @(negedge clk);
         indata = img[i];
         indata_clk = 1'b1;
      end
      @(negedge clk);
      indata_clk = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      clear_mon();
   endtask

   always @(posedge clk) begin
      logic s;
      logic [7:0] d;
      s = indata_clk;
      d = indata;
      #1;
      if (done && error) both_hi++;
      if (mem_write) begin
         wr_cnt++;
         if (wr_cnt == 1) first_data = mem_data;
         if (!s || mem_data !== d) wr_bad++;
         if (exp_addr.size() == 0) wr_bad++;
         else begin
            if (mem_addr !== exp_addr[0] || mem_data !== exp_data[0]) wr_bad++;
            void'(exp_addr.pop_front());
            void'(exp_data.pop_front());
            if (exp_addr.size() == 0) done_at_last = done;
            else if (done) early_done++;
         end
      end
   end

   initial begin
      logic [7:0] f6, f7;
      // strobes under reset must be ignored
      indata = 8'h4E;
      indata_clk = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_mem_write", mem_write, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_done_err", {done, error}, 0);
      chk("rst_hdr_regs", {mapper, mirroring, prg_units, chr_units, chr_ram}, 0);
      indata_clk = 1'b0;
      @(negedge clk); reset = 1'b0;
      clear_mon();

      // 2x16K PRG + 8K CHR, vertical mirroring, continuous strobe
      build_image(8'd2, 8'd1, 8'h01, 8'h00);
      model();
      send(0, img.size(), 0);
      repeat (2) @(negedge clk);
      chk("a_writes", wr_cnt, 40960);
      chk("a_wr_bad", wr_bad, 0);
      chk("a_done_last", done_at_last, 1);
      chk("a_early_done", early_done, 0);
      chk("a_flags", {done, error, mapper, mirroring, chr_ram}, {2'b10, 8'h00, 1'b1, 1'b0});
      chk("a_units", {prg_units, chr_units}, {8'd2, 8'd1});

      // partial image every third cycle, then asynchronous reset mid-PRG
      do_reset();
      f6 = 8'($urandom) & 8'hFB;
      f7 = 8'($urandom);
      build_image(8'd1, 8'd1, f6, f7);
      model();
      send(0, 16 + 1000, 1);
      repeat (2) @(negedge clk);
      chk("c_writes", wr_cnt, 1000);
      chk("c_wr_bad", wr_bad, 0);
      chk("c_mapper", {mapper, mirroring}, {f7[7:4], f6[7:4], f6[0]});
      chk("c_not_done", done, 0);
      @(negedge clk); #2 reset = 1'b1;
      #1;
      chk("c_async_clr", {mem_addr, mem_data, mem_write, done, error}, 0);
      chk("c_async_hdr", {mapper, mirroring, prg_units, chr_units, chr_ram}, 0);
      @(negedge clk); reset = 1'b0;
      clear_mon();

      // trainer image with random strobe gaps, then trailing bytes after done
      build_image(8'd1, 8'd0, 8'h14, 8'h40);
      model();
      send(0, img.size(), 2);
      repeat (2) @(negedge clk);
      chk("b_writes", wr_cnt, 16384);
      chk("b_wr_bad", wr_bad, 0);
      chk("b_first_data", first_data, img[528]);
      chk("b_done_last", done_at_last, 1);
      chk("b_flags", {done, error, mapper, chr_ram}, {2'b10, 8'h41, 1'b1});
      clear_mon();
      send(16, 20, 0);
      repeat (2) @(negedge clk);
      chk("b_after_done", {wr_cnt, 1'b0, done, error}, {32'd0, 1'b0, 2'b10});

      // bad magic at byte 2
      do_reset();
      build_image(8'd1, 8'd0, 8'h00, 8'h00);
      img[2] = 8'h00;
      model();
      send(0, 2, 0);
      chk("m_err_before", error, 0);
      @(negedge clk); indata = img[2]; indata_clk = 1'b1;
      @(posedge clk); #1;
      chk("m_err_next", error, 1);
      @(negedge clk); indata_clk = 1'b0;
      send(3, img.size() - 3, 0);
      repeat (2) @(negedge clk);
      chk("m_result", {wr_cnt, 1'b0, done, error}, {32'd0, 1'b0, 2'b01});

      // prg_units out of range
      for (int k = 0; k < 2; k++) begin
         do_reset();
         build_image((k == 0) ? 8'd0 : 8'd129, 8'd1, 8'h00, 8'h00);
         model();
         send(0, 15, 0);
         chk("p_err_before", error, 0);
         @(negedge clk); indata = img[15]; indata_clk = 1'b1;
         @(posedge clk); #1;
         chk("p_err_byte15", error, 1);
         @(negedge clk); indata_clk = 1'b0;
         send(16, img.size() - 16, 0);
         repeat (2) @(negedge clk);
         chk("p_result", {wr_cnt, 1'b0, done, error}, {32'd0, 1'b0, 2'b01});
      end

      chk("done_err_excl", both_hi, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
